// File: rtl/pdm_decimator.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// pdm_decimator
//
// Recovers 16-bit unsigned PCM samples from the 1-bit delta-sigma stream of the
// dac block. The filter is a third-order CIC decimator that runs on the
// modulator clock and decimates by R = 2**DECIM_LOG2. With the default
// DECIM_LOG2 = 9, a 20.48 MHz clock gives 40 kHz samples.
//
// Ports
//   clk    : modulator clock. All state changes on the rising edge.
//   arst_n : asynchronous active-low reset. Clears every register.
//   din    : PDM bit, sampled every clk. 1 = +full scale, 0 = zero.
//   sync   : one-clk pulse. It clears the decimation phase on the next edge.
//            If it arrives on the tick cycle, that sample is dropped.
//   dout   : unsigned PCM sample. It holds its value between valid strobes.
//   valid  : one-clk strobe, high in the cycle where dout shows a new sample.
//   phase  : current decimation counter value (debug / alignment).
//
// Output protocol: this block has no handshake and no backpressure.
// - valid is a pure strobe, high for exactly one clk per sample.
// - dout changes only in the cycle where valid is high.
// - Any consumer must capture dout while valid is high.
// -----------------------------------------------------------------------------
module pdm_decimator #(
  parameter int DECIM_LOG2 = 9
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  din,
  input  logic                  sync,
  output logic [15:0]           dout,
  output logic                  valid,
  output logic [DECIM_LOG2-1:0] phase
);

  // CIC growth is 3*log2(R) bits. One extra bit holds the exact full-scale
  // value R**3.
  localparam int ACC_W = 3 * DECIM_LOG2 + 1;

  localparam logic [DECIM_LOG2-1:0] PHASE_LAST = '1;
  localparam logic [DECIM_LOG2-1:0] PHASE_ONE  = DECIM_LOG2'(1);

  // Integrators and comb delay registers. All arithmetic is modulo 2**ACC_W.
  // Integrator wrap-around is cancelled by the combs, so it is harmless.
  logic [ACC_W-1:0] i1, i2, i3;
  logic [ACC_W-1:0] d1, d2, d3;
  logic [ACC_W-1:0] c1, c2, c3;
  logic [ACC_W-1:0] din_ext;
  logic             tick;
  logic [15:0]      pcm;

  assign din_ext = {{(ACC_W-1){1'b0}}, din};

  // The last phase of a decimation period, unless sync is realigning it.
  assign tick = (phase == PHASE_LAST) && !sync;

  // Comb chain. It is evaluated every cycle but only registered on tick.
  always_comb begin
    c1 = i3 - d1;
    c2 = c1 - d2;
    c3 = c2 - d3;
  end

  // The comb output lies in 0..2**(ACC_W-1).
  // - The top bit is set only at exact full scale, so the output saturates.
  // - Otherwise the 16 bits below the top bit form the sample.
  // - Bits below the output LSB are truncated.
  always_comb begin
    if (c3[ACC_W-1]) begin
      pcm = 16'hFFFF;
    end else begin
      pcm = c3[ACC_W-2 -: 16];
    end
  end

  logic c3_unused_lsbs;
  assign c3_unused_lsbs = ^c3[ACC_W-18:0];

  // Integrators run every clk, independent of phase and sync.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      i1 <= '0;
      i2 <= '0;
      i3 <= '0;
    end else begin
      i1 <= i1 + din_ext;
      i2 <= i2 + i1;
      i3 <= i3 + i2;
    end
  end

  // Phase counter. It wraps naturally at R because its width is DECIM_LOG2.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      phase <= '0;
    end else if (sync) begin
      phase <= '0;
    end else begin
      phase <= phase + PHASE_ONE;
    end
  end

  // Comb delay registers and output register, updated once per period.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      d1    <= '0;
      d2    <= '0;
      d3    <= '0;
      dout  <= '0;
      valid <= 1'b0;
    end else begin
      valid <= tick;
      if (tick) begin
        d1   <= i3;
        d2   <= c1;
        d3   <= c2;
        dout <= pcm;
      end
    end
  end

endmodule

// File: tb/tb_pdm_decimator.sv
`timescale 1ns/1ps
module tb_pdm_decimator;

  localparam int R = 512;

  localparam logic [1:0] K_EXACT = 2'd0;
  localparam logic [1:0] K_BELOW = 2'd1;
  localparam logic [1:0] K_ANY   = 2'd2;
  localparam logic [1:0] K_NEAR  = 2'd3;

  localparam int MODE_HOLD   = 0;
  localparam int MODE_TOGGLE = 1;
  localparam int MODE_SD     = 2;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        din = 1'b0;
  logic        sync = 1'b0;
  logic [15:0] dout;
  logic        valid;
  logic [8:0]  phase;

  int checks = 0;
  int failures = 0;

  logic [15:0] exp_q[$];
  logic [1:0]  kind_q[$];

  int          din_mode = MODE_HOLD;
  logic [15:0] sd_acc = 16'h0000;

  logic [15:0] last_dout;
  logic        last_valid = 1'b0;
  logic        rst_seen = 1'b1;

  pdm_decimator #(.DECIM_LOG2(9)) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .din    (din),
    .sync   (sync),
    .dout   (dout),
    .valid  (valid),
    .phase  (phase)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  always @(negedge arst_n) rst_seen = 1'b1;

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [15:0] e;
    logic [1:0]  k;
    if (!arst_n) rst_seen = 1'b1;
    if (arst_n && !rst_seen) begin
      checks++;
      if (!valid && dout !== last_dout) begin
        failures++;
        $display("FAIL dout_hold: dout=%h changed without valid (was %h)", dout, last_dout);
      end
      checks++;
      if (valid && last_valid) begin
        failures++;
        $display("FAIL valid_width: valid=%b for two clks, required one", valid);
      end
    end
    if (arst_n && valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid: dout=%h phase=%0d, no sample expected", dout, phase);
      end else begin
        e = exp_q.pop_front();
        k = kind_q.pop_front();
        case (k)
          K_EXACT: begin
            checks++;
            if (dout !== e) begin
              failures++;
              $display("FAIL sample_exact: dout=%h required %h", dout, e);
            end
          end
          K_BELOW: begin
            checks++;
            if (!(dout < 16'hFFFF)) begin
              failures++;
              $display("FAIL sample_transient: dout=%h required below ffff", dout);
            end
          end
          K_NEAR: begin
            checks++;
            if ((dout > e + 16'd1) || (dout + 16'd1 < e)) begin
              failures++;
              $display("FAIL sample_near: dout=%h required %h +/-1", dout, e);
            end
          end
          default: ;
        endcase
      end
    end
    if (arst_n) rst_seen = 1'b0;
    last_dout  = dout;
    last_valid = valid;
  end

  // ---------------- driver tasks ----------------
  task automatic push_exp(input logic [1:0] kind, input logic [15:0] val);
    kind_q.push_back(kind);
    exp_q.push_back(val);
  endtask

  // Advance to the next falling edge and update din for the active pattern.
  task automatic step_neg();
    logic [16:0] s;
    @(negedge clk);
    case (din_mode)
      MODE_TOGGLE: din = ~din;
      MODE_SD: begin
        s      = {1'b0, sd_acc} + 17'h04000;
        sd_acc = s[15:0];
        din    = s[16];
      end
      default: ;
    endcase
  endtask

  task automatic do_reset(input logic init_din, input int mode);
    arst_n   = 1'b0;
    sync     = 1'b0;
    din      = init_din;
    din_mode = mode;
    sd_acc   = 16'h0000;
    repeat (2) @(negedge clk);
    exp_q.delete();
    kind_q.delete();
    arst_n = 1'b1;
  endtask

  // Count falling edges until valid is seen, or until the budget runs out.
  task automatic wait_valid(input int budget, output int n);
    n = 0;
    do begin
      step_neg();
      n++;
    end while (!valid && n < budget);
    if (!valid) begin
      checks++;
      failures++;
      $display("FAIL valid_timeout: no valid within %0d clks", budget);
    end
  endtask

  task automatic check_drained(input string name);
    step_neg();
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: %0d expected samples never arrived, required 0", name, exp_q.size());
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #1;
    checks++;
    if (dout !== 16'h0000) begin
      failures++;
      $display("FAIL reset_dout: dout=%h required 0000", dout);
    end
    checks++;
    if (valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid: valid=%b required 0", valid);
    end
    checks++;
    if (phase !== 9'd0) begin
      failures++;
      $display("FAIL reset_phase: phase=%0d required 0", phase);
    end
    do_reset(1'b0, MODE_HOLD);
    step_neg();
    checks++;
    if (phase !== 9'd1) begin
      failures++;
      $display("FAIL phase_incr: phase=%0d required 1", phase);
    end
  endtask

  task automatic test_zero();
    int n;
    do_reset(1'b0, MODE_HOLD);
    for (int v = 0; v < 5; v++) push_exp(K_EXACT, 16'h0000);
    for (int v = 0; v < 5; v++) begin
      wait_valid(R + 100, n);
      checks++;
      if (n != R) begin
        failures++;
        $display("FAIL zero_spacing: valid %0d after %0d clks required %0d", v, n, R);
      end
      checks++;
      if (phase !== 9'd0) begin
        failures++;
        $display("FAIL zero_phase_at_valid: phase=%0d required 0", phase);
      end
    end
    check_drained("zero");
  endtask

  task automatic test_ones();
    int n;
    do_reset(1'b1, MODE_HOLD);
    push_exp(K_BELOW, 16'h0000);
    push_exp(K_BELOW, 16'h0000);
    for (int v = 0; v < 3; v++) push_exp(K_EXACT, 16'hFFFF);
    for (int v = 0; v < 5; v++) wait_valid(R + 100, n);
    check_drained("ones");
  endtask

  task automatic test_alternate();
    int n;
    do_reset(1'b1, MODE_TOGGLE);
    push_exp(K_ANY, 16'h0000);
    push_exp(K_ANY, 16'h0000);
    for (int v = 0; v < 3; v++) push_exp(K_EXACT, 16'h8000);
    for (int v = 0; v < 5; v++) wait_valid(R + 100, n);
    check_drained("alternate");
  endtask

  task automatic test_loopback();
    int n;
    do_reset(1'b0, MODE_SD);
    for (int v = 0; v < 3; v++) push_exp(K_ANY, 16'h0000);
    for (int v = 0; v < 3; v++) push_exp(K_NEAR, 16'h4000);
    for (int v = 0; v < 6; v++) wait_valid(R + 100, n);
    check_drained("loopback");
  endtask

  task automatic test_sync();
    int n;
    do_reset(1'b0, MODE_HOLD);
    push_exp(K_EXACT, 16'h0000);
    wait_valid(R + 100, n);
    repeat (R - 1) step_neg();
    checks++;
    if (phase !== 9'd511) begin
      failures++;
      $display("FAIL sync_pre_phase: phase=%0d required 511", phase);
    end
    sync = 1'b1;
    step_neg();
    sync = 1'b0;
    checks++;
    if (valid !== 1'b0) begin
      failures++;
      $display("FAIL sync_tick_suppress: valid=%b required 0", valid);
    end
    checks++;
    if (phase !== 9'd0) begin
      failures++;
      $display("FAIL sync_phase_clear: phase=%0d required 0", phase);
    end
    push_exp(K_EXACT, 16'h0000);
    wait_valid(R + 100, n);
    checks++;
    if (n != R) begin
      failures++;
      $display("FAIL sync_tick_spacing: valid after %0d clks required %0d", n, R);
    end
    repeat (200) step_neg();
    checks++;
    if (phase !== 9'd200) begin
      failures++;
      $display("FAIL sync_mid_pre_phase: phase=%0d required 200", phase);
    end
    sync = 1'b1;
    step_neg();
    sync = 1'b0;
    checks++;
    if (phase !== 9'd0) begin
      failures++;
      $display("FAIL sync_mid_phase_clear: phase=%0d required 0", phase);
    end
    push_exp(K_EXACT, 16'h0000);
    wait_valid(R + 100, n);
    checks++;
    if (n != R) begin
      failures++;
      $display("FAIL sync_mid_spacing: valid after %0d clks required %0d", n, R);
    end
    check_drained("sync");
  endtask

  task automatic test_mid_reset();
    int n;
    do_reset(1'b1, MODE_HOLD);
    push_exp(K_BELOW, 16'h0000);
    wait_valid(R + 100, n);
    repeat (300) step_neg();
    checks++;
    if (phase !== 9'd300) begin
      failures++;
      $display("FAIL midrst_pre_phase: phase=%0d required 300", phase);
    end
    arst_n = 1'b0;
    #1;
    checks++;
    if (dout !== 16'h0000) begin
      failures++;
      $display("FAIL midrst_dout: dout=%h required 0000", dout);
    end
    checks++;
    if (valid !== 1'b0) begin
      failures++;
      $display("FAIL midrst_valid: valid=%b required 0", valid);
    end
    checks++;
    if (phase !== 9'd0) begin
      failures++;
      $display("FAIL midrst_phase: phase=%0d required 0", phase);
    end
    step_neg();
    arst_n = 1'b1;
    push_exp(K_BELOW, 16'h0000);
    push_exp(K_BELOW, 16'h0000);
    push_exp(K_EXACT, 16'hFFFF);
    push_exp(K_EXACT, 16'hFFFF);
    wait_valid(R + 100, n);
    checks++;
    if (n != R) begin
      failures++;
      $display("FAIL midrst_first_valid: valid after %0d clks required %0d", n, R);
    end
    for (int v = 0; v < 3; v++) wait_valid(R + 100, n);
    check_drained("midrst");
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    test_reset();
    test_zero();
    test_ones();
    test_alternate();
    test_loopback();
    test_sync();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
